// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a single-outstanding instruction memory
// port and fills the IF/ID pipeline register, with redirect, stall and flush.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_D,
    input  logic        flush_D,
    input  logic [1:0]  pc_SEL,
    input  logic [31:0] jalr_target,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc4_D,
    output logic        valid_D,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] pend_pc;
    logic [XLEN-1:0] hold_inst;
    logic [XLEN-1:0] hold_pc;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            ifid_load;
    logic [XLEN-1:0] load_inst;
    logic [XLEN-1:0] load_pc;

    // Redirect decode; JALR targets are forced halfword-aligned
    assign redirect = (pc_SEL == 2'b01) || (pc_SEL == 2'b11);
    assign target   = (pc_SEL == 2'b01) ? (jalr_target & 32'hFFFF_FFFE) : br_target;

    // Select what (if anything) is written into IF/ID this cycle
    always_comb begin
        ifid_load = 1'b0;
        load_inst = imem_rdata;
        load_pc   = req_addr;
        case (state)
            FETCH: begin
                if (imem_ack && !redirect && !stall_D) begin
                    ifid_load = 1'b1;
                end
            end
            HOLD: begin
                if (!redirect && !stall_D) begin
                    ifid_load = 1'b1;
                    load_inst = hold_inst;
                    load_pc   = hold_pc;
                end
            end
            default: begin
                ifid_load = 1'b0;
            end
        endcase
    end

    // Fetch FSM: request address, pending redirect, one-entry hold buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_addr  <= RESET_PC;
            pend_pc   <= '0;
            hold_inst <= '0;
            hold_pc   <= '0;
            imem_req  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (redirect) begin
                        if (imem_ack) begin
                            req_addr <= target;
                        end else begin
                            pend_pc <= target;
                            state   <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        if (stall_D) begin
                            hold_inst <= imem_rdata;
                            hold_pc   <= req_addr;
                            state     <= HOLD;
                            imem_req  <= 1'b0;
                        end else begin
                            req_addr <= req_addr + PC_STEP;
                        end
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        pend_pc <= target;
                    end
                    if (imem_ack) begin
                        req_addr <= redirect ? target : pend_pc;
                        state    <= FETCH;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        req_addr <= target;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end else if (!stall_D) begin
                        req_addr <= hold_pc + PC_STEP;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID register: flush beats stall, stall beats load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_D  <= NOP_INST;
            pc_D    <= '0;
            pc4_D   <= PC_STEP;
            valid_D <= 1'b0;
        end else if (flush_D) begin
            inst_D  <= NOP_INST;
            valid_D <= 1'b0;
        end else if (!stall_D && ifid_load) begin
            inst_D  <= load_inst;
            pc_D    <= load_pc;
            pc4_D   <= load_pc + PC_STEP;
            valid_D <= 1'b1;
        end
    end

    assign imem_addr = req_addr;
    assign opcode    = inst_D[6:0];
    assign funct3    = inst_D[14:12];
    assign funct7    = inst_D[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard: stimulus queues expected
// memory handshakes and IF/ID deliveries, a negedge monitor checks them.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ifid_t;

    logic        clk;
    logic        reset;
    logic        stall_D;
    logic        flush_D;
    logic [1:0]  pc_SEL;
    logic [31:0] jalr_target;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst_D;
    logic [31:0] pc_D;
    logic [31:0] pc4_D;
    logic        valid_D;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    int checks = 0;
    int errors = 0;

    logic [31:0] aq[$];
    ifid_t       dq[$];

    logic [31:0] exp_a;
    ifid_t       exp_d;
    logic [31:0] last_pc;
    logic [31:0] last_inst;
    logic        last_valid = 1'b0;

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall_D    (stall_D),
        .flush_D    (flush_D),
        .pc_SEL     (pc_SEL),
        .jalr_target(jalr_target),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_D     (inst_D),
        .pc_D       (pc_D),
        .pc4_D      (pc4_D),
        .valid_D    (valid_D),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: the word returned depends only on the address presented
    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic exp_req(input logic [31:0] a);
        aq.push_back(a);
    endtask

    task automatic exp_out(input logic [31:0] pc);
        ifid_t d;
        d.inst = mem_word(pc);
        d.pc   = pc;
        d.pc4  = pc + 32'd4;
        dq.push_back(d);
    endtask

    task automatic step(input logic ack, input logic stall, input logic flush,
                        input logic [1:0] sel, input logic [31:0] jt, input logic [31:0] bt);
        imem_ack    = ack;
        stall_D     = stall;
        flush_D     = flush;
        pc_SEL      = sel;
        jalr_target = jt;
        br_target   = bt;
        @(posedge clk);
        #1;
    endtask

    task automatic seq(input logic ack);
        step(ack, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    // Monitor: accepted requests and newly presented IF/ID contents
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req && imem_ack) begin
                if (aq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req actual=%h required=none", imem_addr);
                end else begin
                    exp_a = aq.pop_front();
                    chk("req_addr", imem_addr, exp_a);
                end
            end
            if (valid_D && (!last_valid || pc_D !== last_pc || inst_D !== last_inst)) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=%h required=none", pc_D);
                end else begin
                    exp_d = dq.pop_front();
                    chk("out_inst", inst_D, exp_d.inst);
                    chk("out_pc", pc_D, exp_d.pc);
                    chk("out_pc4", pc4_D, exp_d.pc4);
                    chk("out_opcode", 32'(opcode), 32'(exp_d.inst[6:0]));
                    chk("out_funct3", 32'(funct3), 32'(exp_d.inst[14:12]));
                    chk("out_funct7", 32'(funct7), 32'(exp_d.inst[31:25]));
                end
            end
        end
        last_valid = valid_D;
        last_pc    = pc_D;
        last_inst  = inst_D;
    end

    initial begin
        reset       = 1'b0;
        stall_D     = 1'b0;
        flush_D     = 1'b0;
        pc_SEL      = 2'b00;
        jalr_target = 32'h0;
        br_target   = 32'h0;
        imem_ack    = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_inst", inst_D, NOP);
        chk("rst_pc", pc_D, 32'h0);
        chk("rst_pc4", pc4_D, 32'h4);
        chk("rst_valid", 32'(valid_D), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // IDLE ignores ack, then requests at RESET_PC
        seq(1'b1);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);

        // Zero-wait streaming
        for (int a = 0; a < 16; a += 4) begin
            exp_req(32'(a));
            exp_out(32'(a));
            seq(1'b1);
        end
        chk("stream_valid", 32'(valid_D), 32'd1);
        chk("stream_pc", pc_D, 32'hC);

        // Wait states at 0x10
        repeat (3) begin
            seq(1'b0);
            chk("wait_addr", imem_addr, 32'h10);
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_pc", pc_D, 32'hC);
        end
        for (int a = 16; a < 32; a += 4) begin
            exp_req(32'(a));
            exp_out(32'(a));
            step(1'b1, 1'b0, 1'b0, (a == 24) ? 2'b10 : 2'b00, 32'h0, 32'h0);
        end

        // Stall on ack at 0x20 goes to HOLD
        exp_req(32'h20);
        step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
        chk("hold_req", 32'(imem_req), 32'd0);
        step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
        chk("hold_req2", 32'(imem_req), 32'd0);
        chk("hold_pc", pc_D, 32'h1C);
        exp_out(32'h20);
        seq(1'b0);
        chk("hold_next_addr", imem_addr, 32'h24);
        chk("hold_next_req", 32'(imem_req), 32'd1);

        // Flush with an ack drops the word but the PC advances
        exp_req(32'h24);
        exp_out(32'h24);
        seq(1'b1);
        exp_req(32'h28);
        step(1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
        chk("flush_ack_valid", 32'(valid_D), 32'd0);
        chk("flush_ack_inst", inst_D, NOP);
        chk("flush_ack_addr", imem_addr, 32'h2C);
        for (int a = 44; a < 64; a += 4) begin
            exp_req(32'(a));
            exp_out(32'(a));
            seq(1'b1);
        end

        // Branch redirect while waiting at 0x40, with flush
        step(1'b0, 1'b0, 1'b1, 2'b11, 32'h0, 32'h100);
        chk("drain_valid", 32'(valid_D), 32'd0);
        chk("drain_inst", inst_D, NOP);
        chk("drain_pc", pc_D, 32'h3C);
        chk("drain_addr", imem_addr, 32'h40);
        chk("drain_req", 32'(imem_req), 32'd1);
        seq(1'b0);
        chk("drain_addr2", imem_addr, 32'h40);
        exp_req(32'h40);
        seq(1'b1);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_valid", 32'(valid_D), 32'd0);
        exp_req(32'h100);
        exp_out(32'h100);
        seq(1'b1);
        exp_req(32'h104);
        exp_out(32'h104);
        seq(1'b1);

        // JALR redirect with simultaneous ack
        exp_req(32'h108);
        step(1'b1, 1'b0, 1'b0, 2'b01, 32'h203, 32'h0);
        chk("jalr_addr", imem_addr, 32'h202);
        chk("jalr_pc", pc_D, 32'h104);
        exp_req(32'h202);
        exp_out(32'h202);
        seq(1'b1);

        // Redirect out of HOLD discards the buffered word
        exp_req(32'h206);
        step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
        chk("hold2_req", 32'(imem_req), 32'd0);
        step(1'b0, 1'b1, 1'b0, 2'b11, 32'h0, 32'h300);
        chk("hold_redir_addr", imem_addr, 32'h300);
        chk("hold_redir_req", 32'(imem_req), 32'd1);
        chk("hold_redir_pc", pc_D, 32'h202);
        exp_req(32'h300);
        exp_out(32'h300);
        seq(1'b1);

        // PC wrap at the top of the address space
        exp_req(32'h304);
        step(1'b1, 1'b0, 1'b0, 2'b11, 32'h0, 32'hFFFF_FFFC);
        chk("wrap_start", imem_addr, 32'hFFFF_FFFC);
        exp_req(32'hFFFF_FFFC);
        exp_out(32'hFFFF_FFFC);
        seq(1'b1);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc4", pc4_D, 32'h0);
        exp_req(32'h0);
        exp_out(32'h0);
        seq(1'b1);

        // A second redirect in DRAIN overwrites the pending target
        step(1'b0, 1'b0, 1'b0, 2'b11, 32'h0, 32'h500);
        step(1'b0, 1'b0, 1'b0, 2'b01, 32'h601, 32'h0);
        chk("drain2_addr", imem_addr, 32'h4);
        exp_req(32'h4);
        seq(1'b1);
        chk("overwrite_addr", imem_addr, 32'h600);

        // Reset asserted mid-DRAIN takes effect immediately
        step(1'b0, 1'b0, 1'b0, 2'b11, 32'h0, 32'h700);
        chk("pre_rst_addr", imem_addr, 32'h600);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_inst", inst_D, NOP);
        chk("mid_rst_pc", pc_D, 32'h0);
        chk("mid_rst_pc4", pc4_D, 32'h4);
        chk("mid_rst_valid", 32'(valid_D), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        pc_SEL = 2'b00;
        chk("post_rst_req0", 32'(imem_req), 32'd0);
        seq(1'b1);
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
        exp_req(32'h0);
        exp_out(32'h0);
        seq(1'b1);
        exp_req(32'h4);
        exp_out(32'h4);
        seq(1'b1);

        repeat (3) seq(1'b0);
        chk("req_queue_empty", 32'(aq.size()), 32'd0);
        chk("out_queue_empty", 32'(dq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
